// File: rtl/sum_zero_det_seq_pkg.sv
// Shared types and helpers for the sliced zero-sum sequencer.
package sum_zero_det_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/SumZeroDet.sv
// Constant-time detector: Z = ((A + B + CI) mod 2^width) == 0, no carry chain.
module SumZeroDet #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic             Z
);

  logic [width-1:0] w_k;

  // A zero sum forces the carry into bit i to be A|B of bit i-1, and that
  // carry must equal A^B at bit i for the sum bit to vanish.
  assign w_k = ((A | B) << 1) | width'(CI);
  assign Z   = ~|((A ^ B) ^ w_k);

endmodule

// File: rtl/sum_zero_det_seq.sv
// Multi-cycle zero-sum detector: one width-bit slice per cycle, LSB first.
// Optional macro SUM_ZERO_DET_SEQ_EARLY_EXIT_EN ends the run at the first nonzero slice.
module sum_zero_det_seq
  import sum_zero_det_seq_pkg::*;
#(
  parameter  int unsigned width  = 8,
  parameter  int unsigned chunks = 4,
  localparam int unsigned IW     = idx_width(chunks),
  localparam int unsigned N      = width * chunks
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          InValid,
  output logic          InReady,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic          CI,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          Z,
  output logic [IW-1:0] FirstNZ
);

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_carry;
  logic            r_zacc;
  logic [IW-1:0]   r_idx;
  logic            r_z;
  logic [IW-1:0]   r_first;

  logic [width-1:0] w_a_sl;
  logic [width-1:0] w_b_sl;
  logic             w_zs;
  logic             w_co;
  logic             w_last;

  assign w_a_sl = r_a[r_idx*width +: width];
  assign w_b_sl = r_b[r_idx*width +: width];
  assign w_last = (r_idx == IW'(chunks - 1));

  // Carry-out is the (width+1)-bit slice sum exceeding the slice range.
  assign w_co = ({1'b0, w_a_sl} + {1'b0, w_b_sl} + {{width{1'b0}}, r_carry})
                > {1'b0, {width{1'b1}}};

  SumZeroDet #(.width(width)) u_slice_det (
    .A  (w_a_sl),
    .B  (w_b_sl),
    .CI (r_carry),
    .Z  (w_zs)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_idx   <= '0;
      r_z     <= 1'b0;
      r_first <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= CI;
            r_zacc  <= 1'b1;
            r_idx   <= '0;
            r_first <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_carry <= w_co;
          r_zacc  <= r_zacc & w_zs;
          if (r_zacc && !w_zs) r_first <= r_idx;
`ifdef SUM_ZERO_DET_SEQ_EARLY_EXIT_EN
          if (!w_zs) begin
            r_z     <= 1'b0;
            r_state <= DONE;
          end else if (w_last) begin
            r_z     <= r_zacc & w_zs;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`else
          if (w_last) begin
            r_z     <= r_zacc & w_zs;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`endif
        end
        DONE: begin
          if (OutReady) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign InReady  = (r_state == IDLE);
  assign OutValid = (r_state == DONE);
  assign Z        = r_z;
  assign FirstNZ  = r_first;

endmodule

// File: tb/tb_sum_zero_det_seq.sv
// Directed bench for sum_zero_det_seq (width=8, chunks=4).
module tb_sum_zero_det_seq;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;
`ifdef SUM_ZERO_DET_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        z;
    logic [1:0]  f;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        InValid;
  logic        InReady;
  logic [31:0] A;
  logic [31:0] B;
  logic        CI;
  logic        OutValid;
  logic        OutReady;
  logic        Z;
  logic [1:0]  FirstNZ;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sum_zero_det_seq #(.width(W), .chunks(C)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .CI       (CI),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Z        (Z),
    .FirstNZ  (FirstNZ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands for one cycle; returns at the negedge of cycle t+1.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci);
    chk({tag, "_inready"}, InReady, 1);
    InValid = 1'b1;
    A = a;
    B = b;
    CI = ci;
    @(negedge CLK);
    InValid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic ez, input logic [1:0] ef);
    int cyc;
    int lat;
    cyc = 1;
    while (!OutValid && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    lat = (EARLY && !ez) ? int'(ef) + 2 : int'(C) + 1;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_z"}, Z, ez);
    chk({tag, "_fnz"}, FirstNZ, ef);
  endtask

  task automatic retire(input string tag);
    OutReady = 1'b1;
    @(negedge CLK);
    OutReady = 1'b0;
    chk({tag, "_ov_clr"}, OutValid, 0);
    chk({tag, "_idle"}, InReady, 1);
  endtask

  vec_t vecs[9] = '{
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2'd0},
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 2'd0},
    '{32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 2'd1},
    '{32'h1234_5678, 32'hEDCB_A988, 1'b0, 1'b1, 2'd0},
    '{32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0},
    '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2'd3},
    '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 2'd3},
    '{32'h0000_FF00, 32'h0000_0100, 1'b0, 1'b0, 2'd2},
    '{32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b1, 2'd0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int last_acc;
    int n_acc;
    int n_res;

    RST = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    A = '0;
    B = '0;
    CI = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_inready", InReady, 1);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_z", Z, 0);
    chk("rst_fnz", FirstNZ, 0);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(tag, vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_result(tag, vecs[i].z, vecs[i].f);
      retire(tag);
    end

    // Result backpressure with a new request waiting.
    start_op("bp", 32'h0000_0100, 32'h0, 1'b0);
    wait_result("bp", 1'b0, 2'd1);
    InValid = 1'b1;
    A = 32'h0;
    B = 32'h0;
    CI = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_ov_hold", OutValid, 1);
      chk("bp_z_hold", Z, 0);
      chk("bp_fnz_hold", FirstNZ, 1);
      chk("bp_inready_lo", InReady, 0);
    end
    OutReady = 1'b1;
    @(negedge CLK);
    OutReady = 1'b0;
    chk("bp_ret_idle", InReady, 1);
    chk("bp_ret_ov", OutValid, 0);
    @(negedge CLK);
    InValid = 1'b0;
    chk("bp_new_accepted", InReady, 0);
    wait_result("bp_new", 1'b1, 2'd0);
    retire("bp_new");

    // Reset while RUN is on slice 2.
    start_op("rst_run", 32'h0100_0000, 32'h0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstrun_inready", InReady, 1);
    chk("rstrun_ov", OutValid, 0);
    chk("rstrun_z", Z, 0);
    chk("rstrun_fnz", FirstNZ, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (OutValid) seen = 1'b1;
    end
    chk("rstrun_no_result", seen, 0);

    // Back-to-back operation with both handshakes held high.
    A = 32'h8000_0000;
    B = 32'h8000_0000;
    CI = 1'b0;
    InValid = 1'b1;
    OutReady = 1'b1;
    last_acc = -1;
    n_acc = 0;
    n_res = 0;
    for (int k = 0; k < 24; k++) begin
      if (InReady) begin
        if (last_acc >= 0) chk("b2b_gap", k - last_acc, 6);
        last_acc = k;
        n_acc++;
      end
      if (OutValid) begin
        chk("b2b_z", Z, 1);
        n_res++;
      end
      if (k == 23) InValid = 1'b0;
      @(negedge CLK);
    end
    OutReady = 1'b0;
    chk("b2b_accepts", n_acc, 4);
    chk("b2b_results", n_res, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sum_zero_det_seq.md
Name: sum_zero_det_seq

Overview:
- Multi-cycle sequencer for zero-sum detection on operands wider than one detector slice. It computes Z = ((A + B + CI) mod 2^(width*chunks)) == 0.
- Wide operands are processed one width-bit slice per cycle, LSB slice first, through a single SumZeroDet instance. A slice carry is chained between slices.
- Valid/ready handshakes on both input and result. Used where a full-width constant-time detector is too large, e.g. wide compare/flag units.

Parameters:
- width, 8, slice width in bits (SumZeroDet width).
- chunks, 4, number of slices; operand width N = width*chunks; must be >= 1.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- InValid  input  1  operand request valid.
- InReady  output  1  block can accept operands.
- A  input  width*chunks  operand A.
- B  input  width*chunks  operand B.
- CI  input  1  carry in.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts result.
- Z  output  1  all-zeroes sum flag.
- FirstNZ  output  $clog2(chunks) (min 1)  index of the lowest slice whose sum is nonzero; 0 when Z=1.

Behaviour:
- Clocking and reset:
  - Single clock CLK. Reset is synchronous and active-high on RST.
  - On RST: state=IDLE, Z=0, FirstNZ=0, slice index=0, carry reg=0, OutValid=0. InReady=1 from the first cycle after reset.
  - RST in any state, including mid-RUN or DONE, aborts the operation, discards operands and produces no result.
- FSM states:
  - IDLE: InReady=1, OutValid=0. On InValid&InReady, register A, B, CI; set carry=CI, zacc=1, idx=0, FirstNZ=0; go to RUN.
  - RUN: InReady=0, OutValid=0. Each cycle, slice idx of the registered A/B with carry-in `carry` drives the SumZeroDet instance, giving zs.
    - Slice carry-out co = bit width of (Aslice + Bslice + carry), computed in-line at width+1 bits.
    - Update: carry<=co; zacc<=zacc&zs; if zacc==1 and zs==0, FirstNZ<=idx.
    - If idx==chunks-1: Z<=zacc&zs, go to DONE. Otherwise idx<=idx+1.
  - DONE: OutValid=1, InReady=0. Z and FirstNZ are held stable until OutValid&OutReady, then go to IDLE.
  - InValid is ignored outside IDLE.
- Timing:
  - Operands accepted in cycle t: RUN occupies cycles t+1..t+chunks; OutValid is asserted in cycle t+chunks+1.
  - With OutReady held high, back-to-back throughput is one operation per chunks+2 cycles.
  - No input/output bypass: a new accept cannot occur in the same cycle as result retirement.
- Arithmetic:
  - Only the low N bits of the sum are checked; the final carry-out is discarded.
  - Carries ripple across slices exactly as in a full N-bit add, so A=all-ones, B=0, CI=1 gives Z=1.
- Outputs InReady and OutValid are decoded from the state register only. They have no combinational path from InValid or OutReady.

Optional Feature:
- Macro: SUM_ZERO_DET_SEQ_EARLY_EXIT_EN.
- Defined: in RUN, the first slice with zs==0 sets Z<=0 and FirstNZ<=idx and transitions directly to DONE. OutValid then appears in cycle t+idx+2, and remaining slices are skipped.
- Undefined: fixed latency chunks+1 cycles for every operation; all slices are processed; Z and FirstNZ values are identical to the defined case.

Decomposition:
- Package sum_zero_det_seq_pkg holds:
  - state enum typedef {IDLE, RUN, DONE} (2-bit);
  - function for index width: max(1, $clog2(chunks)).
- No new sub-module. The existing SumZeroDet (width=width) is instantiated once as the slice detector.
- Slice mux, carry, and FSM stay in this module.

Test Plan (width=8, chunks=4, N=32):
- A=0, B=0, CI=0 accepted at t -> OutValid at t+5, Z=1, FirstNZ=0.
- A=32'hFFFF_FFFF, B=0, CI=1 -> Z=1, FirstNZ=0, exercising full carry ripple.
- A=32'h0000_0100, B=0, CI=0 -> Z=0, FirstNZ=1; OutValid at t+5 without the macro, t+3 with SUM_ZERO_DET_SEQ_EARLY_EXIT_EN.
- Result backpressure: OutReady=0 for 5 cycles after OutValid while InValid=1 with new operands -> OutValid, Z, FirstNZ stable and InReady=0. After OutReady=1, IDLE next cycle and the new operands are accepted then.
- RST=1 for one cycle in RUN (idx=2) -> next cycle IDLE, InReady=1, OutValid=0, Z=0; no stale result ever presented.
- Back-to-back: InValid=1 and OutReady=1 continuously with A=32'h8000_0000, B=32'h8000_0000 -> each result Z=1; accepts every 6 cycles.
